lock_ctrl: RTL and testbench
============================

LOCK_CTRL -- requirements
Module: lock_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  CODE_LEN, 4, digits per code;
  DEFAULT_CODE, 16'h1234, code after reset, first digit in MS nibble;
  MAX_TRIES, 3, consecutive failures before lockout;
  ERR_CYCLES, 4, ERROR dwell;
  LOCKOUT_CYCLES, 16, LOCKOUT dwell;
  UNLOCK_CYCLES, 20, UNLOCKED dwell before auto-relock;
  IDLE_CYCLES, 10, INPUT inactivity timeout.
REQ-002 Ports (name  direction  width  meaning), one per line:
  clk  in  1  single clock, rising edge;
  reset  in  1  asynchronous, active-low reset;
  key_valid  in  1  one-cycle strobe, key_digit valid;
  key_digit  in  4  digit value 0-9; values 10-15 treated as digits, no check;
  key_enter  in  1  one-cycle strobe, submit entry;
  key_clear  in  1  one-cycle strobe, abort entry / relock;
  prog_en  in  1  level, arms code programming while UNLOCKED;
  state  out  3  current state encoding;
  unlock  out  1  high iff state==UNLOCKED;
  lockout  out  1  high iff state==LOCKOUT;
  digit_cnt  out  3  digits buffered, 0..CODE_LEN;
  fail_cnt  out  2  consecutive failed attempts;
  prog_done  out  1  one-cycle pulse, new code stored.

Function
REQ-003 State encoding: LOCKED 000, INPUT 001, VERIFY 010, ERROR 011, UNLOCKED 100, LOCKOUT 101; 110/111 shall transition to LOCKED next cycle.
REQ-004 All outputs registered or decoded from registered state; no input-to-output combinational path.
REQ-005 Strobe priority when simultaneous: key_clear > key_enter > key_valid.
REQ-006 Digit buffer: shift-left by 4, new digit into LS nibble, digit_cnt+1; when digit_cnt==CODE_LEN further digits ignored, no wrap, no shift.
REQ-007 LOCKED: key_valid -> buffer digit, digit_cnt=1, go INPUT; key_enter/key_clear ignored.
REQ-008 INPUT: key_valid buffers per REQ-006; key_clear -> digit_cnt=0, go LOCKED; key_enter -> VERIFY; IDLE_CYCLES consecutive cycles with no strobe -> digit_cnt=0, go LOCKED, fail_cnt unchanged.
REQ-009 VERIFY lasts exactly one cycle, ignores inputs; match = (digit_cnt==CODE_LEN) and (buffer==code_reg).
REQ-010 VERIFY match -> UNLOCKED, fail_cnt=0; mismatch -> fail_cnt+1, then LOCKOUT if new fail_cnt==MAX_TRIES else ERROR; digit_cnt=0 on leaving VERIFY.
REQ-011 ERROR: exactly ERR_CYCLES cycles, all strobes ignored, then LOCKED.
REQ-012 LOCKOUT: exactly LOCKOUT_CYCLES cycles, all strobes ignored, then LOCKED with fail_cnt=0.
REQ-013 UNLOCKED: exactly UNLOCK_CYCLES cycles then LOCKED; key_clear -> LOCKED next cycle; key_valid buffers per REQ-006 and restarts dwell timer.
REQ-014 Programming: in UNLOCKED, key_enter with prog_en=1 and digit_cnt==CODE_LEN -> code_reg=buffer, prog_done=1 one cycle, digit_cnt=0, dwell restarts; any other key_enter in UNLOCKED -> digit_cnt=0 only.
REQ-015 One shared dwell/idle counter, loaded on every state entry; width sized for largest dwell parameter, no overflow.

Reset
REQ-016 reset low asynchronously forces: state=LOCKED, digit_cnt=0, fail_cnt=0, buffer=0, timer=0, prog_done=0, code_reg=DEFAULT_CODE; mid-operation reset aborts any state and discards programmed code.
REQ-017 First state transition permitted on first rising clk edge after reset deasserts.

Verification
REQ-018 Digits 1,2,3,4 then enter -> VERIFY one cycle, UNLOCKED for 20 cycles, unlock=1, then LOCKED, fail_cnt=0.
REQ-019 Digits 1,2,3,5 enter, three times -> fail_cnt 1,2 with ERROR 4 cycles each; third -> LOCKOUT 16 cycles, strobes ignored, then LOCKED, fail_cnt=0.
REQ-020 Digits 1,2,3 enter -> mismatch (short entry), ERROR; digits 1,2,3,4,9 enter -> 9 ignored, UNLOCKED.
REQ-021 Digit 7, then 10 idle cycles -> LOCKED, digit_cnt=0; key_clear and key_enter same cycle in INPUT -> LOCKED.
REQ-022 Unlocked, prog_en=1, digits 5,6,7,8 enter -> prog_done pulse; relock; 1,2,3,4 fails, 5,6,7,8 unlocks.
REQ-023 reset asserted mid-UNLOCKED after programming 5678 -> immediate LOCKED; 1,2,3,4 unlocks.

Source files
------------

// File: rtl/lock_ctrl_if.sv
// Keypad strobes in, lock status out; clk and reset stay outside the bundle.
interface lock_ctrl_if;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       key_enter;
  logic       key_clear;
  logic       prog_en;
  logic [2:0] state;
  logic       unlock;
  logic       lockout;
  logic [2:0] digit_cnt;
  logic [1:0] fail_cnt;
  logic       prog_done;

  modport master (
    output key_valid, key_digit, key_enter, key_clear, prog_en,
    input  state, unlock, lockout, digit_cnt, fail_cnt, prog_done
  );

  modport slave (
    input  key_valid, key_digit, key_enter, key_clear, prog_en,
    output state, unlock, lockout, digit_cnt, fail_cnt, prog_done
  );
endinterface

// File: rtl/lock_ctrl.sv
// Keypad code lock: digit entry, code compare, retry lockout, in-place reprogramming.
//   state    | meaning
//   LOCKED   | waiting for the first digit
//   INPUT    | collecting digits, inactivity timeout running
//   VERIFY   | single-cycle compare of entry against stored code
//   ERROR    | wrong-code penalty dwell, strobes ignored
//   UNLOCKED | open, auto-relock after dwell, code may be reprogrammed
//   LOCKOUT  | too many consecutive failures, strobes ignored
module lock_ctrl #(
  parameter int                    CODE_LEN       = 4,
  parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE   = 16'h1234,
  parameter int                    MAX_TRIES      = 3,
  parameter int                    ERR_CYCLES     = 4,
  parameter int                    LOCKOUT_CYCLES = 16,
  parameter int                    UNLOCK_CYCLES  = 20,
  parameter int                    IDLE_CYCLES    = 10
) (
  input  logic       clk,
  input  logic       reset,
  lock_ctrl_if.slave bus
);

  localparam int BUF_W = 4 * CODE_LEN;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_DWELL = max_of(max_of(ERR_CYCLES, LOCKOUT_CYCLES),
                                    max_of(UNLOCK_CYCLES, IDLE_CYCLES));
  // The timer is loaded with dwell-1 and left on reaching zero.
  localparam int TW = (MAX_DWELL > 1) ? $clog2(MAX_DWELL) : 1;

  localparam logic [TW-1:0] T_ERR     = TW'(ERR_CYCLES - 1);
  localparam logic [TW-1:0] T_LOCKOUT = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_UNLOCK  = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] T_IDLE    = TW'(IDLE_CYCLES - 1);
  localparam logic [2:0]    FULL_CNT  = 3'(CODE_LEN);

  typedef enum logic [2:0] {
    S_LOCKED   = 3'b000,
    S_INPUT    = 3'b001,
    S_VERIFY   = 3'b010,
    S_ERROR    = 3'b011,
    S_UNLOCKED = 3'b100,
    S_LOCKOUT  = 3'b101
  } state_t;

  state_t           state_q;
  logic [2:0]       digit_cnt_q;
  logic [1:0]       fail_cnt_q;
  logic [BUF_W-1:0] buffer_q;
  logic [BUF_W-1:0] code_q;
  logic [TW-1:0]    timer_q;
  logic             prog_done_q;

  logic       digit_full;
  logic       code_match;
  logic       timer_done;
  logic [1:0] fail_inc;
  logic       last_try;

  assign digit_full = (digit_cnt_q == FULL_CNT);
  assign code_match = digit_full && (buffer_q == code_q);
  assign timer_done = (timer_q == '0);
  assign fail_inc   = fail_cnt_q + 2'd1;
  assign last_try   = (int'(fail_inc) == MAX_TRIES);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_LOCKED;
      digit_cnt_q <= '0;
      fail_cnt_q  <= '0;
      buffer_q    <= '0;
      timer_q     <= '0;
      prog_done_q <= 1'b0;
      code_q      <= DEFAULT_CODE;
    end else begin
      prog_done_q <= 1'b0;
      case (state_q)
        S_LOCKED: begin
          if (bus.key_valid && !bus.key_clear && !bus.key_enter) begin
            buffer_q    <= BUF_W'({buffer_q, bus.key_digit});
            digit_cnt_q <= 3'd1;
            timer_q     <= T_IDLE;
            state_q     <= S_INPUT;
          end
        end
        S_INPUT: begin
          if (bus.key_clear) begin
            digit_cnt_q <= '0;
            timer_q     <= '0;
            state_q     <= S_LOCKED;
          end else if (bus.key_enter) begin
            timer_q <= '0;
            state_q <= S_VERIFY;
          end else if (bus.key_valid) begin
            if (!digit_full) begin
              buffer_q    <= BUF_W'({buffer_q, bus.key_digit});
              digit_cnt_q <= digit_cnt_q + 3'd1;
            end
            timer_q <= T_IDLE;
          end else if (timer_done) begin
            digit_cnt_q <= '0;
            state_q     <= S_LOCKED;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        S_VERIFY: begin
          digit_cnt_q <= '0;
          if (code_match) begin
            fail_cnt_q <= '0;
            timer_q    <= T_UNLOCK;
            state_q    <= S_UNLOCKED;
          end else if (last_try) begin
            fail_cnt_q <= fail_inc;
            timer_q    <= T_LOCKOUT;
            state_q    <= S_LOCKOUT;
          end else begin
            fail_cnt_q <= fail_inc;
            timer_q    <= T_ERR;
            state_q    <= S_ERROR;
          end
        end
        S_ERROR: begin
          if (timer_done) state_q <= S_LOCKED;
          else            timer_q <= timer_q - TW'(1);
        end
        S_LOCKOUT: begin
          if (timer_done) begin
            fail_cnt_q <= '0;
            state_q    <= S_LOCKED;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        S_UNLOCKED: begin
          // Dwell countdown first; strobes below may override it.
          if (timer_done) begin
            digit_cnt_q <= '0;
            state_q     <= S_LOCKED;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
          if (bus.key_clear) begin
            digit_cnt_q <= '0;
            timer_q     <= '0;
            state_q     <= S_LOCKED;
          end else if (bus.key_enter) begin
            digit_cnt_q <= '0;
            if (bus.prog_en && digit_full) begin
              code_q      <= buffer_q;
              prog_done_q <= 1'b1;
              timer_q     <= T_UNLOCK;
              state_q     <= S_UNLOCKED;
            end
          end else if (bus.key_valid) begin
            if (!digit_full) begin
              buffer_q    <= BUF_W'({buffer_q, bus.key_digit});
              digit_cnt_q <= digit_cnt_q + 3'd1;
            end
            timer_q <= T_UNLOCK;
            state_q <= S_UNLOCKED;
          end
        end
        default: begin
          digit_cnt_q <= '0;
          timer_q     <= '0;
          state_q     <= S_LOCKED;
        end
      endcase
    end
  end

  assign bus.state     = state_q;
  assign bus.unlock    = (state_q == S_UNLOCKED);
  assign bus.lockout   = (state_q == S_LOCKOUT);
  assign bus.digit_cnt = digit_cnt_q;
  assign bus.fail_cnt  = fail_cnt_q;
  assign bus.prog_done = prog_done_q;

endmodule

// File: tb/tb_lock_ctrl.sv
// Bench for lock_ctrl: vector table, directed multi-cycle sequences, random traffic vs model.
module tb_lock_ctrl;
  localparam int CODE_LEN       = 4;
  localparam int MAX_TRIES      = 3;
  localparam int ERR_CYCLES     = 4;
  localparam int LOCKOUT_CYCLES = 16;
  localparam int UNLOCK_CYCLES  = 20;
  localparam int IDLE_CYCLES    = 10;

  localparam int S_LOCKED   = 0;
  localparam int S_INPUT    = 1;
  localparam int S_VERIFY   = 2;
  localparam int S_ERROR    = 3;
  localparam int S_UNLOCKED = 4;
  localparam int S_LOCKOUT  = 5;

  logic clk = 1'b0;
  logic reset;

  lock_ctrl_if bus ();

  lock_ctrl #(
    .CODE_LEN       (CODE_LEN),
    .DEFAULT_CODE   (16'h1234),
    .MAX_TRIES      (MAX_TRIES),
    .ERR_CYCLES     (ERR_CYCLES),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
    .UNLOCK_CYCLES  (UNLOCK_CYCLES),
    .IDLE_CYCLES    (IDLE_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode, typed digits, stored code, failures, cycles left in dwell.
  int m_mode;
  int m_entry[$];
  int m_code[$];
  int m_fails;
  int m_left;
  bit m_pd;

  typedef struct {
    int v; int d; int e; int c; int p;
    int st; int dc; int fc;
  } vec_t;
  vec_t tbl[$];

  int kind, gap, len, sel, n_obs;
  int code_copy[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = S_LOCKED;
    m_entry.delete();
    m_code = {1, 2, 3, 4};
    m_fails = 0;
    m_left = 0;
    m_pd = 1'b0;
  endfunction

  function automatic void model_add(input int d);
    if (m_entry.size() < CODE_LEN) m_entry.push_back(d);
  endfunction

  function automatic bit model_match();
    if (m_entry.size() != CODE_LEN) return 1'b0;
    for (int i = 0; i < CODE_LEN; i++)
      if (m_entry[i] != m_code[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_dwell_tick(input bool_clear_fails);
    m_left--;
    if (m_left == 0) begin
      m_mode = S_LOCKED;
      m_entry.delete();
      if (bool_clear_fails) m_fails = 0;
    end
  endfunction

  function automatic void model_step(input int v, input int d, input int e, input int c, input int p);
    m_pd = 1'b0;
    case (m_mode)
      S_LOCKED: if (c == 0 && e == 0 && v != 0) begin
        m_entry.delete();
        m_entry.push_back(d);
        m_mode = S_INPUT;
        m_left = IDLE_CYCLES;
      end
      S_INPUT: begin
        if (c != 0) begin
          m_entry.delete();
          m_mode = S_LOCKED;
        end else if (e != 0) m_mode = S_VERIFY;
        else if (v != 0) begin
          model_add(d);
          m_left = IDLE_CYCLES;
        end else model_dwell_tick(1'b0);
      end
      S_VERIFY: begin
        if (model_match()) begin
          m_fails = 0;
          m_mode = S_UNLOCKED;
          m_left = UNLOCK_CYCLES;
        end else begin
          m_fails++;
          m_mode = (m_fails == MAX_TRIES) ? S_LOCKOUT : S_ERROR;
          m_left = (m_fails == MAX_TRIES) ? LOCKOUT_CYCLES : ERR_CYCLES;
        end
        m_entry.delete();
      end
      S_ERROR:   model_dwell_tick(1'b0);
      S_LOCKOUT: model_dwell_tick(1'b1);
      S_UNLOCKED: begin
        if (c != 0) begin
          m_entry.delete();
          m_mode = S_LOCKED;
        end else if (e != 0) begin
          if (p != 0 && m_entry.size() == CODE_LEN) begin
            m_code = m_entry;
            m_pd = 1'b1;
            m_left = UNLOCK_CYCLES;
            m_entry.delete();
          end else begin
            m_entry.delete();
            model_dwell_tick(1'b0);
          end
        end else if (v != 0) begin
          model_add(d);
          m_left = UNLOCK_CYCLES;
        end else model_dwell_tick(1'b0);
      end
      default: m_mode = S_LOCKED;
    endcase
  endfunction

  task automatic check_model();
    logic [10:0] act, exp;
    act = {bus.state, bus.unlock, bus.lockout, bus.digit_cnt, bus.fail_cnt, bus.prog_done};
    exp = {3'(m_mode), m_mode == S_UNLOCKED, m_mode == S_LOCKOUT,
           3'(m_entry.size()), 2'(m_fails), m_pd};
    check("model", 32'(act), 32'(exp));
  endtask

  // Called at posedge+1; applies inputs for one edge and checks at the next posedge+1.
  task automatic step(input int v, input int d, input int e, input int c, input int p);
    bus.key_valid = (v != 0);
    bus.key_digit = 4'(d);
    bus.key_enter = (e != 0);
    bus.key_clear = (c != 0);
    bus.prog_en   = (p != 0);
    @(posedge clk);
    model_step(v, d, e, c, p);
    #1;
    check_model();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0);
  endtask

  task automatic try_code(input int a, input int b, input int c, input int d, input int p);
    step(1, a, 0, 0, p);
    step(1, b, 0, 0, p);
    step(1, c, 0, 0, p);
    step(1, d, 0, 0, p);
    step(0, 0, 1, 0, p);
    idle();
  endtask

  task automatic do_reset();
    bus.key_valid = 1'b0;
    bus.key_enter = 1'b0;
    bus.key_clear = 1'b0;
    bus.prog_en   = 1'b0;
    bus.key_digit = 4'd0;
    reset = 1'b0;
    #2;
    model_reset();
    check("reset_state", 32'(bus.state), S_LOCKED);
    check("reset_outs", 32'({bus.unlock, bus.lockout, bus.digit_cnt, bus.fail_cnt, bus.prog_done}), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic count_state(input int st, input int limit, input bit noisy, output int n);
    n = 0;
    while (int'(bus.state) == st && n < limit) begin
      n++;
      if (noisy) step(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 0);
      else idle();
    end
  endtask

  task automatic add_vec(input int v, input int d, input int e, input int c, input int p,
                         input int st, input int dc, input int fc);
    vec_t r;
    r.v = v; r.d = d; r.e = e; r.c = c; r.p = p;
    r.st = st; r.dc = dc; r.fc = fc;
    tbl.push_back(r);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    #1;
    do_reset();

    // Entry, wrong code, penalty dwell, ignored strobes, clear+enter, unlock and UNLOCKED keys.
    add_vec(1, 1, 0, 0, 0, S_INPUT, 1, 0);
    add_vec(1, 2, 0, 0, 0, S_INPUT, 2, 0);
    add_vec(0, 0, 0, 0, 0, S_INPUT, 2, 0);
    add_vec(1, 3, 0, 0, 0, S_INPUT, 3, 0);
    add_vec(1, 5, 0, 0, 0, S_INPUT, 4, 0);
    add_vec(1, 9, 0, 0, 0, S_INPUT, 4, 0);
    add_vec(0, 0, 1, 0, 0, S_VERIFY, 4, 0);
    add_vec(0, 0, 0, 0, 0, S_ERROR, 0, 1);
    add_vec(1, 1, 0, 0, 0, S_ERROR, 0, 1);
    add_vec(0, 0, 1, 0, 0, S_ERROR, 0, 1);
    add_vec(0, 0, 0, 1, 0, S_ERROR, 0, 1);
    add_vec(0, 0, 1, 0, 0, S_LOCKED, 0, 1);
    add_vec(0, 0, 0, 1, 0, S_LOCKED, 0, 1);
    add_vec(0, 0, 1, 0, 0, S_LOCKED, 0, 1);
    add_vec(1, 1, 0, 0, 0, S_INPUT, 1, 1);
    add_vec(1, 2, 0, 0, 0, S_INPUT, 2, 1);
    add_vec(1, 3, 0, 0, 0, S_INPUT, 3, 1);
    add_vec(1, 4, 0, 0, 0, S_INPUT, 4, 1);
    add_vec(0, 0, 1, 1, 0, S_LOCKED, 0, 1);
    add_vec(1, 1, 0, 0, 0, S_INPUT, 1, 1);
    add_vec(1, 2, 0, 0, 0, S_INPUT, 2, 1);
    add_vec(1, 3, 0, 0, 0, S_INPUT, 3, 1);
    add_vec(1, 4, 0, 0, 0, S_INPUT, 4, 1);
    add_vec(0, 0, 1, 0, 0, S_VERIFY, 4, 1);
    add_vec(0, 0, 0, 0, 0, S_UNLOCKED, 0, 0);
    add_vec(1, 9, 0, 0, 0, S_UNLOCKED, 1, 0);
    add_vec(0, 0, 1, 0, 0, S_UNLOCKED, 0, 0);
    add_vec(1, 5, 0, 0, 1, S_UNLOCKED, 1, 0);
    add_vec(0, 0, 1, 0, 1, S_UNLOCKED, 0, 0);
    add_vec(0, 0, 0, 1, 0, S_LOCKED, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d, tbl[i].e, tbl[i].c, tbl[i].p);
      check($sformatf("vec%0d", i),
            32'({bus.state, bus.digit_cnt, bus.fail_cnt, bus.unlock, bus.lockout}),
            32'({3'(tbl[i].st), 3'(tbl[i].dc), 2'(tbl[i].fc),
                 tbl[i].st == S_UNLOCKED, tbl[i].st == S_LOCKOUT}));
    end

    // Correct code: one VERIFY cycle, full UNLOCKED dwell, relock.
    do_reset();
    step(1, 1, 0, 0, 0); step(1, 2, 0, 0, 0); step(1, 3, 0, 0, 0); step(1, 4, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    count_state(S_VERIFY, 5, 1'b0, n_obs);
    check("verify_len", 32'(n_obs), 1);
    count_state(S_UNLOCKED, 100, 1'b0, n_obs);
    check("unlock_dwell", 32'(n_obs), UNLOCK_CYCLES);
    check("relock_state", 32'({bus.state, bus.fail_cnt}), 32'({3'(S_LOCKED), 2'd0}));

    // Three wrong codes: two ERROR dwells, then LOCKOUT with strobes ignored.
    do_reset();
    for (int k = 1; k <= MAX_TRIES; k++) begin
      try_code(1, 2, 3, 5, 0);
      check($sformatf("try%0d_fail_cnt", k), 32'(bus.fail_cnt), 32'(k));
      if (k < MAX_TRIES) begin
        count_state(S_ERROR, 100, 1'b1, n_obs);
        check($sformatf("try%0d_err_dwell", k), 32'(n_obs), ERR_CYCLES);
      end else begin
        check("lockout_flag", 32'(bus.lockout), 1);
        count_state(S_LOCKOUT, 100, 1'b1, n_obs);
        check("lockout_dwell", 32'(n_obs), LOCKOUT_CYCLES);
      end
      check($sformatf("try%0d_after", k), 32'(bus.state), S_LOCKED);
    end
    check("lockout_clears_fails", 32'(bus.fail_cnt), 0);

    // Short entry fails; a fifth digit is dropped.
    do_reset();
    step(1, 1, 0, 0, 0); step(1, 2, 0, 0, 0); step(1, 3, 0, 0, 0);
    step(0, 0, 1, 0, 0); idle();
    check("short_entry", 32'(bus.state), S_ERROR);
    count_state(S_ERROR, 100, 1'b0, n_obs);
    step(1, 1, 0, 0, 0); step(1, 2, 0, 0, 0); step(1, 3, 0, 0, 0); step(1, 4, 0, 0, 0);
    step(1, 9, 0, 0, 0);
    check("fifth_digit_dropped", 32'(bus.digit_cnt), 4);
    step(0, 0, 1, 0, 0); idle();
    check("five_digit_unlock", 32'(bus.state), S_UNLOCKED);

    // Inactivity timeout, then clear beating enter.
    do_reset();
    step(1, 7, 0, 0, 0);
    count_state(S_INPUT, 100, 1'b0, n_obs);
    check("idle_timeout", 32'(n_obs), IDLE_CYCLES);
    check("idle_after", 32'({bus.state, bus.digit_cnt}), 32'({3'(S_LOCKED), 3'd0}));
    step(1, 7, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    check("clear_over_enter", 32'(bus.state), S_LOCKED);

    // Reprogram to 5678, old code then fails, new code opens.
    do_reset();
    try_code(1, 2, 3, 4, 0);
    step(1, 5, 0, 0, 1); step(1, 6, 0, 0, 1); step(1, 7, 0, 0, 1); step(1, 8, 0, 0, 1);
    step(0, 0, 1, 0, 1);
    check("prog_done_pulse", 32'(bus.prog_done), 1);
    idle();
    check("prog_done_drop", 32'(bus.prog_done), 0);
    step(0, 0, 0, 1, 0);
    check("prog_relock", 32'(bus.state), S_LOCKED);
    try_code(1, 2, 3, 4, 0);
    check("old_code_rejected", 32'(bus.state), S_ERROR);
    count_state(S_ERROR, 100, 1'b0, n_obs);
    try_code(5, 6, 7, 8, 0);
    check("new_code_accepted", 32'(bus.state), S_UNLOCKED);

    // Reset mid-UNLOCKED restores the default code.
    do_reset();
    try_code(1, 2, 3, 4, 0);
    check("default_after_reset", 32'(bus.state), S_UNLOCKED);

    // Random traffic against the model.
    for (int ep = 0; ep < 250; ep++) begin
      kind = int'($urandom_range(0, 9));
      case (kind)
        0, 1, 2: begin
          code_copy = m_code;
          for (int i = 0; i < CODE_LEN; i++) begin
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) idle();
            step(1, code_copy[i], 0, 0, 0);
          end
          step(0, 0, 1, 0, int'($urandom_range(0, 1)));
        end
        3, 4: begin
          len = int'($urandom_range(1, 5));
          for (int i = 0; i < len; i++) step(1, int'($urandom_range(0, 15)), 0, 0, 0);
          step(0, 0, 1, 0, 0);
        end
        5: begin
          len = int'($urandom_range(0, 25));
          for (int i = 0; i < len; i++) idle();
        end
        6, 7: begin
          len = int'($urandom_range(1, 10));
          for (int i = 0; i < len; i++) begin
            sel = int'($urandom_range(0, 4));
            if (sel == 4 && m_mode != S_LOCKED)
              step(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                   int'($urandom_range(0, 1)));
            else
              step(int'(sel == 1), int'($urandom_range(0, 15)), int'(sel == 2),
                   int'(sel == 3), int'($urandom_range(0, 1)));
          end
        end
        8: begin
          if (m_mode == S_UNLOCKED) begin
            for (int i = 0; i < CODE_LEN; i++) step(1, int'($urandom_range(0, 9)), 0, 0, 1);
            step(0, 0, 1, 0, 1);
          end else idle();
        end
        default: begin
          if ($urandom_range(0, 7) == 0) do_reset();
          else idle();
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
